seq_alu_param: RTL and testbench

//  Parametrised multi-cycle ALU: logic ops, add/sub, signed Booth radix-2 multiply and unsigned non-restoring divide
//  on two WIDTH-bit operands. One shared adder and a shift-register datapath (A/Q/M style) sequenced by an FSM.

---
 rtl/seq_alu_pkg.sv | 35 +++
 rtl/seq_alu_addsub.sv | 19 +
 rtl/seq_alu_param.sv | 211 +++++++++++++++++++++
 tb/tb_seq_alu_param.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_alu_pkg.sv
// rtl/seq_alu_pkg.sv - op codes, FSM state encoding and result packing shared by the seq_alu blocks
package seq_alu_pkg;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_ADD  = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_DIV  = 3'b110;
    localparam logic [2:0] OP_RSVD = 3'b111;

    // Widest operand the packing helper can carry.
    localparam int MAX_WIDTH = 64;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_EXEC     = 3'd2,
        S_MUL_ITER = 3'd3,
`ifdef SEQ_ALU_DIV_EN
        S_DIV_ITER = 3'd4,
        S_DIV_FIX  = 3'd5,
`endif
        S_DONE     = 3'd6
    } state_t;

    // {hi, lo} for a w-bit half; callers truncate to 2*w bits.
    function automatic logic [2*MAX_WIDTH-1:0] pack_result(input logic [MAX_WIDTH-1:0] hi,
                                                           input logic [MAX_WIDTH-1:0] lo,
                                                           input int                   w);
        return ({{MAX_WIDTH{1'b0}}, hi} << w) | {{MAX_WIDTH{1'b0}}, lo};
    endfunction

endpackage

// File: rtl/seq_alu_addsub.sv
// rtl/seq_alu_addsub.sv - N-bit adder/subtractor with carry out and signed overflow
module seq_alu_addsub #(
    parameter int N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    logic [N-1:0] b_eff;

    assign b_eff       = sub ? ~b : b;
    assign {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{N{1'b0}}, sub};
    assign ovf         = (a[N-1] == b_eff[N-1]) && (sum[N-1] != a[N-1]);

endmodule

// File: rtl/seq_alu_param.sv
// rtl/seq_alu_param.sv - multi-cycle ALU (logic, add/sub, Booth multiply, divide); divider only with SEQ_ALU_DIV_EN
module seq_alu_param
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic               err,
    output logic               ovf
);

    localparam int CW = $clog2(WIDTH);
    localparam int AW = WIDTH + 1;

    state_t           state, state_n;
    logic [AW-1:0]    a_reg, a_n;
    logic [WIDTH-1:0] q_reg, q_n;
    logic [WIDTH-1:0] m_reg, m_n;
    logic             qm1_reg, qm1_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [2:0]       op_reg, op_n;
    logic [2*WIDTH-1:0] result_n;
    logic             err_n, ovf_n;
    logic [AW-1:0]    booth_val;

    logic [AW-1:0]    add_a, add_b, add_sum;
    logic             add_sub, add_cout, add_ovf;
    logic             unused_cout;

    function automatic logic [2*WIDTH-1:0] pack(input logic [WIDTH-1:0] hi,
                                                input logic [WIDTH-1:0] lo);
        return (2*WIDTH)'(pack_result(MAX_WIDTH'(hi), MAX_WIDTH'(lo), WIDTH));
    endfunction

    seq_alu_addsub #(.N(AW)) u_addsub (
        .a    (add_a),
        .b    (add_b),
        .sub  (add_sub),
        .sum  (add_sum),
        .cout (add_cout),
        .ovf  (add_ovf)
    );

    assign unused_cout = add_cout;
    assign busy        = (state != S_IDLE);
    assign done        = (state == S_DONE);

    // ADD/SUB run with operands in the top WIDTH bits so the adder's own
    // overflow flag is the WIDTH-bit signed overflow.
    always_comb begin
        add_a   = {q_reg, 1'b0};
        add_b   = {m_reg, 1'b0};
        add_sub = (op_reg == OP_SUB);
        case (state)
            S_MUL_ITER: begin
                add_a   = a_reg;
                add_b   = {m_reg[WIDTH-1], m_reg};
                add_sub = q_reg[0] & ~qm1_reg;
            end
`ifdef SEQ_ALU_DIV_EN
            S_DIV_ITER: begin
                add_a   = {a_reg[WIDTH-1:0], q_reg[WIDTH-1]};
                add_b   = {1'b0, m_reg};
                add_sub = ~a_reg[AW-1];
            end
            S_DIV_FIX: begin
                add_a   = a_reg;
                add_b   = {1'b0, m_reg};
                add_sub = 1'b0;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_n   = state;
        a_n       = a_reg;
        q_n       = q_reg;
        m_n       = m_reg;
        qm1_n     = qm1_reg;
        cnt_n     = cnt;
        op_n      = op_reg;
        result_n  = result;
        err_n     = err;
        ovf_n     = ovf;
        booth_val = a_reg;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_LOAD;
                    q_n     = x;
                    m_n     = y;
                    op_n    = op;
                    a_n     = '0;
                    qm1_n   = 1'b0;
                    cnt_n   = '0;
                end
            end
            S_LOAD: begin
                a_n   = '0;
                qm1_n = 1'b0;
                cnt_n = '0;
                case (op_reg)
                    OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB: state_n = S_EXEC;
                    OP_MUL: state_n = S_MUL_ITER;
`ifdef SEQ_ALU_DIV_EN
                    OP_DIV: begin
                        if (m_reg == '0) begin
                            state_n  = S_DONE;
                            result_n = pack(q_reg, {WIDTH{1'b1}});
                            err_n    = 1'b1;
                            ovf_n    = 1'b0;
                        end else begin
                            state_n = S_DIV_ITER;
                        end
                    end
`endif
                    default: begin
                        state_n  = S_DONE;
                        result_n = '0;
                        err_n    = 1'b1;
                        ovf_n    = 1'b0;
                    end
                endcase
            end
            S_EXEC: begin
                state_n = S_DONE;
                err_n   = 1'b0;
                ovf_n   = 1'b0;
                case (op_reg)
                    OP_AND:  result_n = pack('0, q_reg & m_reg);
                    OP_OR:   result_n = pack('0, q_reg | m_reg);
                    OP_XOR:  result_n = pack('0, q_reg ^ m_reg);
                    default: begin
                        result_n = pack({WIDTH{add_sum[AW-1]}}, add_sum[AW-1:1]);
                        ovf_n    = add_ovf;
                    end
                endcase
            end
            S_MUL_ITER: begin
                booth_val = (q_reg[0] ^ qm1_reg) ? add_sum : a_reg;
                a_n       = {booth_val[AW-1], booth_val[AW-1:1]};
                q_n       = {booth_val[0], q_reg[WIDTH-1:1]};
                qm1_n     = q_reg[0];
                cnt_n     = cnt + 1'b1;
                if (cnt == CW'(WIDTH - 1)) begin
                    state_n  = S_DONE;
                    result_n = pack(a_n[WIDTH-1:0], q_n);
                    err_n    = 1'b0;
                    ovf_n    = 1'b0;
                end
            end
`ifdef SEQ_ALU_DIV_EN
            S_DIV_ITER: begin
                a_n   = add_sum;
                q_n   = {q_reg[WIDTH-2:0], ~add_sum[AW-1]};
                cnt_n = cnt + 1'b1;
                if (cnt == CW'(WIDTH - 1)) begin
                    state_n = S_DIV_FIX;
                end
            end
            S_DIV_FIX: begin
                // Negative partial remainder gets one restoring add.
                a_n      = a_reg[AW-1] ? add_sum : a_reg;
                state_n  = S_DONE;
                result_n = pack(a_n[WIDTH-1:0], q_reg);
                err_n    = 1'b0;
                ovf_n    = 1'b0;
            end
`endif
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= S_IDLE;
            a_reg   <= '0;
            q_reg   <= '0;
            m_reg   <= '0;
            qm1_reg <= 1'b0;
            cnt     <= '0;
            op_reg  <= '0;
            result  <= '0;
            err     <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            state   <= state_n;
            a_reg   <= a_n;
            q_reg   <= q_n;
            m_reg   <= m_n;
            qm1_reg <= qm1_n;
            cnt     <= cnt_n;
            op_reg  <= op_n;
            result  <= result_n;
            err     <= err_n;
            ovf     <= ovf_n;
        end
    end

endmodule

// File: tb/tb_seq_alu_param.sv
// tb/tb_seq_alu_param.sv - scoreboard bench for seq_alu_param at WIDTH=8
module tb_seq_alu_param;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op_i = 3'd0;
    logic [7:0]  x_i = 8'd0;
    logic [7:0]  y_i = 8'd0;
    logic        busy, done, err, ovf;
    logic [15:0] result;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [15:0] result;
        logic        err;
        logic        ovf;
        int          lat;
        string       nm;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    seq_alu_param #(.WIDTH(8)) dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .op     (op_i),
        .x      (x_i),
        .y      (y_i),
        .busy   (busy),
        .done   (done),
        .result (result),
        .err    (err),
        .ovf    (ovf)
    );

    function automatic exp_t model(input logic [2:0] o, input logic [7:0] a,
                                   input logic [7:0] b, input string nm);
        exp_t e;
        int sa, sbv, s;
        logic [7:0] lo;
        sa = int'($signed(a));
        sbv = int'($signed(b));
        e.result = 16'h0000;
        e.err = 1'b0;
        e.ovf = 1'b0;
        e.lat = 3;
        e.nm = nm;
        case (o)
            3'b000: e.result = {8'h00, a & b};
            3'b001: e.result = {8'h00, a | b};
            3'b010: e.result = {8'h00, a ^ b};
            3'b011, 3'b100: begin
                s = (o == 3'b011) ? sa + sbv : sa - sbv;
                lo = s[7:0];
                e.result = {{8{lo[7]}}, lo};
                e.ovf = (s > 127) || (s < -128);
            end
            3'b101: begin
                s = sa * sbv;
                e.result = s[15:0];
                e.lat = 10;
            end
            3'b110: begin
`ifdef SEQ_ALU_DIV_EN
                if (b == 8'h00) begin
                    e.result = {a, 8'hFF};
                    e.err = 1'b1;
                    e.lat = 2;
                end else begin
                    e.result = {a % b, a / b};
                    e.lat = 11;
                end
`else
                e.err = 1'b1;
                e.lat = 2;
`endif
            end
            default: begin
                e.err = 1'b1;
                e.lat = 2;
            end
        endcase
        return e;
    endfunction

    task automatic run_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                          input string nm, output logic [15:0] r, output logic e_o,
                          output logic v_o, output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (busy && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        op_i = o;
        x_i = a;
        y_i = b;
        start = 1'b1;
        exp_q.push_back(model(o, a, b, nm));
        @(posedge clk);
        #1;
        start = 1'b0;
        op_i = 3'($urandom);
        x_i = 8'($urandom);
        y_i = 8'($urandom);
        lat = 1;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!done) lat = -1;
        r = result;
        e_o = err;
        v_o = ovf;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({busy, done, err, ovf} !== 4'b0000 || result !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset busy/done/err/ovf got %b result %h exp 0000 / 0000", {busy, done, err, ovf}, result);
        end
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_table(input string grp, input logic [18:0] tbl [8], input int n);
        logic [15:0] r;
        logic e_o, v_o;
        int lat;
        exp_t e;
        for (int i = 0; i < n; i++) begin
            run_op(tbl[i][18:16], tbl[i][15:8], tbl[i][7:0], $sformatf("%s%0d", grp, i), r, e_o, v_o, lat);
            e = exp_q.pop_front();
            n_tests++;
            if (r !== e.result) begin
                n_fail++;
                $display("FAIL %s result got %h exp %h", e.nm, r, e.result);
            end
            n_tests++;
            if (e_o !== e.err || v_o !== e.ovf) begin
                n_fail++;
                $display("FAIL %s err/ovf got %b%b exp %b%b", e.nm, e_o, v_o, e.err, e.ovf);
            end
            n_tests++;
            if (lat != e.lat) begin
                n_fail++;
                $display("FAIL %s latency got %0d exp %0d", e.nm, lat, e.lat);
            end
        end
    endtask

    task automatic test_ops;
        logic [18:0] t [8];
        t = '{{3'b010, 8'hF0, 8'h3C}, {3'b000, 8'hF0, 8'h3C}, {3'b001, 8'hA0, 8'h05},
              {3'b111, 8'h12, 8'h34}, {3'b011, 8'h7F, 8'h01}, {3'b101, 8'hFD, 8'h05},
              {3'b100, 8'h80, 8'h01}, {3'b011, 8'hFF, 8'h01}};
        test_table("mix", t, 8);
        t = '{{3'b100, 8'h05, 8'h07}, {3'b101, 8'h80, 8'h80}, {3'b101, 8'h7F, 8'h80},
              {3'b110, 8'hC8, 8'h07}, {3'b110, 8'h55, 8'h00}, {3'b110, 8'hFF, 8'h01},
              {3'b110, 8'h07, 8'hC8}, {3'b101, 8'h00, 8'h9A}};
        test_table("muldiv", t, 8);
    endtask

    task automatic test_random;
        logic [18:0] t [8];
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 8; i++) begin
                t[i] = {3'($urandom_range(0, 7)), 8'($urandom), ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom)};
            end
            test_table("rnd", t, 8);
        end
    endtask

    task automatic test_handshake;
        exp_t e;
        int lat;
        int guard;
        guard = 0;
        @(negedge clk);
        while (busy && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        op_i = 3'b101;
        x_i = 8'hFD;
        y_i = 8'h05;
        start = 1'b1;
        exp_q.push_back(model(3'b101, 8'hFD, 8'h05, "hs_mul"));
        @(posedge clk);
        #1;
        x_i = 8'h11;
        y_i = 8'h22;
        lat = 1;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        e = exp_q.pop_front();
        n_tests++;
        if (lat != e.lat || result !== e.result) begin
            n_fail++;
            $display("FAIL hs_mul lat/result got %0d/%h exp %0d/%h", lat, result, e.lat, e.result);
        end
        op_i = 3'b011;
        x_i = 8'h7F;
        y_i = 8'h01;
        exp_q.push_back(model(3'b011, 8'h7F, 8'h01, "hs_add"));
        @(posedge clk);
        #1;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL hs_idle busy/done got %b%b exp 00", busy, done);
        end
        n_tests++;
        if (result !== e.result) begin
            n_fail++;
            $display("FAIL hs_hold result got %h exp %h", result, e.result);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL hs_accept busy got %b exp 1", busy);
        end
        start = 1'b0;
        lat = 1;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        e = exp_q.pop_front();
        n_tests++;
        if (lat != e.lat || result !== e.result || ovf !== e.ovf) begin
            n_fail++;
            $display("FAIL hs_add lat/result/ovf got %0d/%h/%b exp %0d/%h/%b", lat, result, ovf, e.lat, e.result, e.ovf);
        end
    endtask

    task automatic test_reset_mid;
        logic [15:0] r;
        logic e_o, v_o;
        int lat;
        int pulses;
        exp_t e;
        int guard;
        guard = 0;
        @(negedge clk);
        while (busy && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        op_i = 3'b101;
        x_i = 8'h7F;
        y_i = 8'h7F;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 16'h0000 || err !== 1'b0 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid busy/done/result got %b%b/%h exp 00/0000", busy, done, result);
        end
        pulses = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        @(negedge clk);
        resetn = 1'b1;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done || busy) pulses++;
        end
        n_tests++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL rst_mid_quiet busy/done cycles got %0d exp 0", pulses);
        end
        run_op(3'b101, 8'hFD, 8'h05, "rst_fresh", r, e_o, v_o, lat);
        e = exp_q.pop_front();
        n_tests++;
        if (r !== e.result || lat != e.lat || e_o !== e.err) begin
            n_fail++;
            $display("FAIL %s result/lat got %h/%0d exp %h/%0d", e.nm, r, lat, e.result, e.lat);
        end
    endtask

    initial begin
        test_reset;
        test_ops;
        test_handshake;
        test_reset_mid;
        test_random;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
